matmul2x2_engine: RTL

Operand-consuming end of the matrix-multiplier demo: accepts two 2x2 matrices of unsigned W-bit elements as two packed beats on a valid/ready input port. It computes C = A×B with one shared multiplier over 8 cycles, then streams the four result elements out on a valid/ready result port. It is the core that the top-level pin wrapper feeds from `ui_in` (matrix A) and `uio_in` (matrix B).

---
 rtl/matmul2x2_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/matmul2x2_engine.sv
// 2x2 unsigned matrix multiplier: two operand rows in, one shared multiplier
// over 8 cycles, four result elements streamed out on a valid/ready port.
module matmul2x2_engine #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a_in,
    input  logic [2*W-1:0] b_in,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W:0]   res_data,
    output logic [1:0]     res_idx,
    output logic           res_last,
    output logic           busy
);

    typedef enum logic [1:0] {
        LOAD0   = 2'd0,
        LOAD1   = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]   a_reg [2][2];
    logic [W-1:0]   b_reg [2][2];
    logic [2*W:0]   c_reg [4];
    logic [2*W-1:0] acc_reg;
    logic [2:0]     step_reg;
    logic [1:0]     idx_reg;

    logic [W-1:0]   a_beat [2];
    logic [W-1:0]   b_beat [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_beat[gi] = a_in[gi*W +: W];
            assign b_beat[gi] = b_in[gi*W +: W];
        end
    endgenerate

    // Step decode: element e = s>>1 at row e>>1, column e&1; k picks the term.
    logic [1:0]     elem;
    logic           term;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] prod;
    logic [2*W:0]   sum;

    assign elem  = step_reg[2:1];
    assign term  = step_reg[0];
    assign mul_a = a_reg[elem[1]][term];
    assign mul_b = b_reg[term][elem[0]];
    assign prod  = (2*W)'(mul_a) * (2*W)'(mul_b);
    assign sum   = {1'b0, acc_reg} + {1'b0, prod};

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            LOAD0: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD1;
            end
            LOAD1: begin
                in_ready = 1'b1;
                if (in_valid) state_next = COMPUTE;
            end
            COMPUTE: begin
                if (step_reg == 3'd7) state_next = OUTPUT;
            end
            OUTPUT: begin
                if (res_ready && idx_reg == 2'd3) state_next = LOAD0;
            end
            default: state_next = LOAD0;
        endcase
    end

    assign res_valid = (state_reg == OUTPUT);
    assign res_data  = res_valid ? c_reg[idx_reg] : '0;
    assign res_idx   = res_valid ? idx_reg : 2'd0;
    assign res_last  = res_valid && (idx_reg == 2'd3);
    assign busy      = (state_reg == COMPUTE) || (state_reg == OUTPUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD0;
            step_reg  <= '0;
            idx_reg   <= '0;
            acc_reg   <= '0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                end
            end
            for (int e = 0; e < 4; e++) c_reg[e] <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD0, LOAD1: begin
                    if (in_valid) begin
                        for (int c = 0; c < 2; c++) begin
                            a_reg[state_reg == LOAD1][c] <= a_beat[c];
                            b_reg[state_reg == LOAD1][c] <= b_beat[c];
                        end
                    end
                    step_reg <= '0;
                    idx_reg  <= '0;
                end
                COMPUTE: begin
                    step_reg <= step_reg + 3'd1;
                    if (!term) acc_reg     <= prod;
                    else       c_reg[elem] <= sum;
                end
                OUTPUT: begin
                    if (res_ready) idx_reg <= idx_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
